voice_alloc: RTL and testbench

VOICE_ALLOC -- requirements
Module: voice_alloc

---
 rtl/voice_alloc_pkg.sv | 24 ++
 rtl/voice_alloc_select.sv | 61 ++++++
 rtl/voice_alloc.sv | 147 ++++++++++++++
 tb/tb_voice_alloc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the voice allocator: event FSM encoding,
// envelope keystate bit position, table field widths and the age saturation helper.
package voice_alloc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_READ   = 2'd2,
        ST_WRITE  = 2'd3
    } evt_state_t;

    localparam int KEYSTATE_BIT = 0;
    localparam int NOTE_W       = 7;
    localparam int AGE_W        = 8;
    localparam int VIDX_W       = 8;
    localparam int ADSR_W       = 128;

    localparam logic [AGE_W-1:0] AGE_MAX = 8'hFF;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + 8'd1;
    endfunction

endpackage

// File: rtl/voice_alloc_select.sv
// Combinational voice chooser: retrigger match first, then lowest free voice,
// then oldest active voice (lowest index on tie). Note-off only matches.
module voice_select
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 16
) (
    input  logic [NUM_VOICES-1:0]        active,
    input  logic [NUM_VOICES*NOTE_W-1:0] notes,
    input  logic [NUM_VOICES*AGE_W-1:0]  ages,
    input  logic [NOTE_W-1:0]            note_num,
    input  logic                         note_on,
    output logic [VIDX_W-1:0]            voice,
    output logic                         hit
);

    logic              match_found;
    logic [VIDX_W-1:0] match_idx;
    logic              free_found;
    logic [VIDX_W-1:0] free_idx;
    logic              steal_found;
    logic [VIDX_W-1:0] steal_idx;
    logic [AGE_W-1:0]  steal_age;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        steal_found = 1'b0;
        steal_idx   = '0;
        steal_age   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!match_found && active[i] && (notes[i*NOTE_W +: NOTE_W] == note_num)) begin
                match_found = 1'b1;
                match_idx   = VIDX_W'(i);
            end
            if (!free_found && !active[i]) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(i);
            end
            // strict compare keeps the lowest index among equally old voices
            if (active[i] && (!steal_found || (ages[i*AGE_W +: AGE_W] > steal_age))) begin
                steal_found = 1'b1;
                steal_idx   = VIDX_W'(i);
                steal_age   = ages[i*AGE_W +: AGE_W];
            end
        end

        voice = '0;
        hit   = 1'b0;
        if (match_found) begin
            voice = match_idx;
            hit   = 1'b1;
        end else if (note_on) begin
            voice = free_found ? free_idx : steal_idx;
            hit   = 1'b1;
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Voice sweep sequencer plus note-event allocator that toggles the envelope keystate bit
// through a read-modify-write of the envelope RAM; write strobe 3 clocks after accept.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_strobe,
    output logic [VIDX_W-1:0]  voice_index,
    output logic               sweep_done,
    input  logic               note_valid,
    output logic               note_ready,
    input  logic               note_on,
    input  logic [NOTE_W-1:0]  note_num,
    output logic [VIDX_W-1:0]  adsr_addr,
    output logic [ADSR_W-1:0]  adsr_din,
    output logic               adsr_write_en,
    input  logic [ADSR_W-1:0]  adsr_dout,
    output logic [VIDX_W-1:0]  alloc_voice,
    output logic               alloc_hit
);

    localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

    // ---------------- sweep ----------------
    logic sweep_busy;
    logic sweep_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_busy  <= 1'b0;
            sweep_phase <= 1'b0;
            voice_index <= '0;
            sweep_done  <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (!sweep_busy) begin
                if (sample_strobe) begin
                    sweep_busy  <= 1'b1;
                    sweep_phase <= 1'b0;
                    voice_index <= '0;
                end
            end else if (!sweep_phase) begin
                sweep_phase <= 1'b1;
            end else begin
                sweep_phase <= 1'b0;
                if (voice_index == LAST_VOICE) begin
                    sweep_busy  <= 1'b0;
                    sweep_done  <= 1'b1;
                    voice_index <= '0;
                end else begin
                    voice_index <= voice_index + 8'd1;
                end
            end
        end
    end

    // ---------------- event FSM ----------------
    evt_state_t state, state_nxt;

    logic                         note_on_q;
    logic [NOTE_W-1:0]            note_num_q;
    logic [NUM_VOICES-1:0]        tbl_active;
    logic [NUM_VOICES*NOTE_W-1:0] tbl_note;
    logic [NUM_VOICES*AGE_W-1:0]  tbl_age;
    logic [VIDX_W-1:0]            sel_voice;
    logic                         sel_hit;
    logic                         accept;

    voice_select #(
        .NUM_VOICES (NUM_VOICES)
    ) u_select (
        .active   (tbl_active),
        .notes    (tbl_note),
        .ages     (tbl_age),
        .note_num (note_num_q),
        .note_on  (note_on_q),
        .voice    (sel_voice),
        .hit      (sel_hit)
    );

    assign note_ready = reset & (state == ST_IDLE);
    assign accept     = note_valid & note_ready;

    always_comb begin
        state_nxt     = state;
        adsr_addr     = '0;
        adsr_din      = '0;
        adsr_write_en = 1'b0;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_LOOKUP;
            ST_LOOKUP: state_nxt = sel_hit ? ST_READ : ST_IDLE;
            ST_READ: begin
                adsr_addr = alloc_voice;
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                // read data for the address presented in READ arrives now
                adsr_addr               = alloc_voice;
                adsr_din                = adsr_dout;
                adsr_din[KEYSTATE_BIT]  = note_on_q;
                adsr_write_en           = 1'b1;
                state_nxt               = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            note_on_q   <= 1'b0;
            note_num_q  <= '0;
            alloc_voice <= '0;
            alloc_hit   <= 1'b0;
            tbl_active  <= '0;
            tbl_note    <= '0;
            tbl_age     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                note_on_q  <= note_on;
                note_num_q <= note_num;
            end
            if (state == ST_LOOKUP) begin
                alloc_voice <= sel_voice;
                alloc_hit   <= sel_hit;
                if (sel_hit) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (sel_voice == VIDX_W'(i)) begin
                            tbl_active[i] <= note_on_q;
                            if (note_on_q) begin
                                tbl_note[i*NOTE_W +: NOTE_W] <= note_num_q;
                                tbl_age[i*AGE_W +: AGE_W]    <= '0;
                            end
                        end else if (note_on_q && tbl_active[i]) begin
                            tbl_age[i*AGE_W +: AGE_W] <= age_inc(tbl_age[i*AGE_W +: AGE_W]);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Scoreboard bench for voice_alloc: stimulus pushes expectations from a reference
// model of the allocation rules; independent monitors pop and compare.
module tb_voice_alloc;

    localparam int NV = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sample_strobe = 1'b0;
    logic         note_valid = 1'b0;
    logic         note_on = 1'b0;
    logic [6:0]   note_num = '0;
    logic [7:0]   voice_index, adsr_addr, alloc_voice;
    logic         sweep_done, note_ready, adsr_write_en, alloc_hit;
    logic [127:0] adsr_din;
    logic [127:0] adsr_dout = '0;

    voice_alloc #(.NUM_VOICES(NV)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .voice_index   (voice_index),
        .sweep_done    (sweep_done),
        .note_valid    (note_valid),
        .note_ready    (note_ready),
        .note_on       (note_on),
        .note_num      (note_num),
        .adsr_addr     (adsr_addr),
        .adsr_din      (adsr_din),
        .adsr_write_en (adsr_write_en),
        .adsr_dout     (adsr_dout),
        .alloc_voice   (alloc_voice),
        .alloc_hit     (alloc_hit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // envelope RAM: fixed random contents, one-clock read latency
    logic [127:0] ram [256];
    always @(posedge clk) adsr_dout <= ram[adsr_addr];

    typedef struct {int cyc; int voice; bit hit;} alloc_exp_t;
    typedef struct {int cyc; logic [7:0] addr; logic [127:0] din;} wr_exp_t;
    alloc_exp_t aq[$];
    wr_exp_t    wq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: voice table as plain integer arrays
    int m_act [NV];
    int m_note[NV];
    int m_age [NV];

    function automatic void model_event(input bit on, input int num, output int v, output bit hit);
        int oldest;
        v   = -1;
        hit = 1'b0;
        for (int i = 0; i < NV; i++)
            if (v < 0 && m_act[i] != 0 && m_note[i] == num) v = i;
        if (on) begin
            if (v < 0)
                for (int i = 0; i < NV; i++)
                    if (v < 0 && m_act[i] == 0) v = i;
            if (v < 0) begin
                oldest = -1;
                for (int i = 0; i < NV; i++)
                    if (m_age[i] > oldest) oldest = m_age[i];
                for (int i = 0; i < NV; i++)
                    if (v < 0 && m_age[i] == oldest) v = i;
            end
            for (int i = 0; i < NV; i++)
                if (i != v && m_act[i] != 0) m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
            m_act[v]  = 1;
            m_note[v] = num;
            m_age[v]  = 0;
            hit = 1'b1;
        end else if (v >= 0) begin
            m_act[v] = 0;
            hit = 1'b1;
        end
    endfunction

    task automatic send(input bit on, input int num, input bit strb);
        int t;
        int v;
        bit hit;
        alloc_exp_t a;
        wr_exp_t w;
        t = 0;
        @(negedge clk);
        while (!note_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!note_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: note_ready stayed 0 for %0d cycles, required 1", t);
            return;
        end
        note_valid    = 1'b1;
        note_on       = on;
        note_num      = num[6:0];
        sample_strobe = strb;
        model_event(on, num, v, hit);
        a.cyc   = cyc + (hit ? 4 : 2);
        a.voice = v;
        a.hit   = hit;
        aq.push_back(a);
        if (hit) begin
            w.cyc  = cyc + 3;
            w.addr = 8'(v);
            w.din  = {ram[v][127:1], on};
            wq.push_back(w);
        end
        @(negedge clk);
        note_valid    = 1'b0;
        sample_strobe = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b0;
        note_valid    = 1'b0;
        sample_strobe = 1'b0;
        #1;
        chk("rst_voice_index", voice_index, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_adsr_addr", adsr_addr, 0);
        chk("rst_adsr_din", adsr_din, 0);
        chk("rst_adsr_write_en", adsr_write_en, 0);
        chk("rst_alloc_voice", alloc_voice, 0);
        chk("rst_alloc_hit", alloc_hit, 0);
        chk("rst_note_ready", note_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_write_en", adsr_write_en, 0);
        aq.delete();
        wq.delete();
        for (int i = 0; i < NV; i++) begin
            m_act[i]  = 0;
            m_note[i] = 0;
            m_age[i]  = 0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", note_ready, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    // event monitor: write strobes and completion of each event
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_ready <= 1'b0;
        end else begin
            if (adsr_write_en) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: adsr_write_en=1 addr=%0h, required no write", adsr_addr);
                end else begin
                    chk("wr_cycle", cyc, wq[0].cyc);
                    chk("wr_addr", adsr_addr, wq[0].addr);
                    chk("wr_din", adsr_din, wq[0].din);
                    wq.delete(0);
                end
            end
            if (note_ready && !prev_ready && aq.size() > 0) begin
                chk("ready_cycle", cyc, aq[0].cyc);
                chk("alloc_hit", alloc_hit, aq[0].hit);
                if (aq[0].hit) chk("alloc_voice", alloc_voice, aq[0].voice);
                aq.delete(0);
            end
            prev_ready <= note_ready;
        end
    end

    // sweep reference: start cycle of the sweep currently running
    int sw_start = 0;
    bit sw_active = 1'b0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_active <= 1'b0;
        end else if (sample_strobe && !(sw_active && (cyc - sw_start) < 2*NV + 1)) begin
            sw_active <= 1'b1;
            sw_start  <= cyc;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("voice_index", voice_index,
                (sw_active && (cyc - sw_start) >= 1 && (cyc - sw_start) <= 2*NV) ? ((cyc - sw_start - 1) / 2) : 0);
            chk("sweep_done", sweep_done, (sw_active && (cyc - sw_start) == 2*NV + 1) ? 1 : 0);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

        do_reset();

        // sweep with events running alongside, including a strobe mid-sweep
        @(negedge clk);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        send(1, 60, 0);
        send(1, 60, 0);
        send(0, 99, 0);
        send(1, 61, 1);
        send(0, 60, 0);
        repeat (40) @(negedge clk);

        // fill all voices then steal the oldest
        do_reset();
        for (int n = 0; n < NV; n++) send(1, n, 0);
        send(1, 16, 0);
        send(0, 16, 0);

        // push ages past 255: only saturation keeps voice 0 the steal target
        do_reset();
        for (int n = 0; n < NV; n++) send(1, n, 0);
        repeat (242) send(1, NV - 1, 0);
        send(1, 100, 0);

        // note accept together with sweep start, then reset mid-flight
        do_reset();
        send(1, 60, 1);
        do_reset();
        repeat (10) @(negedge clk);

        // randomized traffic
        repeat (200) send($urandom_range(0, 9) < 6, $urandom_range(0, 19), $urandom_range(0, 7) == 0);
        repeat (60) @(negedge clk);

        chk("alloc_queue_drained", aq.size(), 0);
        chk("write_queue_drained", wq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
